// File: rtl/cs_parity_engine.sv
`default_nettype none
// ============================================================================
// Module   : cs_parity_engine
// Brief    : Streaming cyclic-shift parity encoder. Accumulates P parity
//            symbols per frame of M data symbols as XORs of rotated data,
//            using a run-time programmable P x M shift table.
// Revision : 1.0 - initial release
// ============================================================================
module cs_parity_engine #(
    parameter int M     = 4,
    parameter int P     = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH),
    parameter int CW    = ($clog2(M) > 1) ? $clog2(M) : 1,
    parameter int RW    = ($clog2(P) > 1) ? $clog2(P) : 1,
    parameter int IW    = ($clog2(P) > 1) ? $clog2(P) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [RW-1:0]    cfg_row,
    input  logic [CW-1:0]    cfg_col,
    input  logic [SW-1:0]    cfg_shift,
    output logic             cfg_err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             s_inv,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IW-1:0]    m_idx,
    output logic             m_last,
    output logic             frame_err
);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_col;
    logic [IW-1:0]      r_m_idx;
    logic               r_inv;
    logic [WIDTH-1:0]   r_m_data;
    logic               r_m_last;
    logic               r_cfg_err;
    logic               r_frame_err;
    logic [WIDTH-1:0]   r_acc [P];
    logic [SW-1:0]      r_tbl [P][M];

    logic [WIDTH-1:0]   w_acc_next [P];
    logic               w_inv_eff;
    logic               w_s_hs;
    logic               w_cfg_ok;
    logic               w_col_last;
    logic [IW-1:0]      w_idx_nxt;

    // Left rotation: out[i] = d[(i - s) mod WIDTH]
    function automatic logic [WIDTH-1:0] f_rot(input logic [WIDTH-1:0] d,
                                               input logic [SW-1:0]    s);
        logic [WIDTH-1:0] o;
        int               k;
        o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            k    = (i + WIDTH - int'(s)) % WIDTH;
            o[i] = d[k[SW-1:0]];
        end
        return o;
    endfunction

    // Inverse mode undoes a rotation by rotating the complement amount
    function automatic logic [SW-1:0] f_eff(input logic [SW-1:0] t,
                                            input logic          inv);
        if (inv && (t != '0))
            return SW'(WIDTH - int'(t));
        else
            return t;
    endfunction

    assign s_ready   = (r_state == S_COLLECT);
    assign m_valid   = (r_state == S_EMIT);
    assign m_data    = r_m_data;
    assign m_idx     = r_m_idx;
    assign m_last    = r_m_last;
    assign cfg_err   = r_cfg_err;
    assign frame_err = r_frame_err;

    assign w_s_hs     = s_valid && (r_state == S_COLLECT);
    assign w_col_last = (r_col == CW'(M - 1));
    assign w_idx_nxt  = r_m_idx + IW'(1);
    // Table edits only between frames, never racing a beat that reads it
    assign w_cfg_ok   = cfg_we && (r_state == S_COLLECT) && (r_col == '0) &&
                        !w_s_hs && (int'(cfg_shift) < WIDTH) &&
                        (int'(cfg_row) < P) && (int'(cfg_col) < M);

    // Next accumulator values for the beat currently on s_data
    always_comb begin
        w_inv_eff = (r_col == '0) ? s_inv : r_inv;
        for (int p = 0; p < P; p++) begin
            if (r_col == '0)
                w_acc_next[p] = f_rot(s_data, f_eff(r_tbl[p][r_col], w_inv_eff));
            else
                w_acc_next[p] = r_acc[p] ^
                                f_rot(s_data, f_eff(r_tbl[p][r_col], w_inv_eff));
        end
    end

    // Collect/emit state machine, shift table and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_col       <= '0;
            r_m_idx     <= '0;
            r_inv       <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_frame_err <= 1'b0;
            for (int p = 0; p < P; p++) begin
                r_acc[p] <= '0;
                for (int m = 0; m < M; m++)
                    r_tbl[p][m] <= SW'(((p + 1) * (m + 1)) % WIDTH);
            end
        end else begin
            r_cfg_err   <= cfg_we && !w_cfg_ok;
            r_frame_err <= 1'b0;
            if (w_cfg_ok)
                r_tbl[cfg_row][cfg_col] <= cfg_shift;

            case (r_state)
                S_COLLECT: begin
                    if (s_valid) begin
                        if (r_col == '0)
                            r_inv <= s_inv;
                        if (w_col_last && s_last) begin
                            for (int p = 0; p < P; p++)
                                r_acc[p] <= w_acc_next[p];
                            r_state  <= S_EMIT;
                            r_col    <= '0;
                            r_m_idx  <= '0;
                            r_m_data <= w_acc_next[0];
                            r_m_last <= (P == 1);
                        end else if (w_col_last || s_last) begin
                            // Malformed frame: drop everything gathered so far
                            for (int p = 0; p < P; p++)
                                r_acc[p] <= '0;
                            r_col       <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            for (int p = 0; p < P; p++)
                                r_acc[p] <= w_acc_next[p];
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (m_ready) begin
                        if (r_m_last) begin
                            r_state  <= S_COLLECT;
                            r_m_idx  <= '0;
                            r_m_data <= '0;
                            r_m_last <= 1'b0;
                        end else begin
                            r_m_idx  <= w_idx_nxt;
                            r_m_data <= r_acc[w_idx_nxt];
                            r_m_last <= (w_idx_nxt == IW'(P - 1));
                        end
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cs_parity_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_parity_engine
// Brief    : Directed self-checking bench for cs_parity_engine (M=P=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_parity_engine;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_row;
    logic [1:0] cfg_col;
    logic [2:0] cfg_shift;
    logic       cfg_err;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_inv;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] m_idx;
    logic       m_last;
    logic       frame_err;

    int n_chk;
    int n_err;

    cs_parity_engine #(.M(4), .P(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_row   (cfg_row),
        .cfg_col   (cfg_col),
        .cfg_shift (cfg_shift),
        .cfg_err   (cfg_err),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_inv     (s_inv),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l, input logic inv);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_inv   = inv;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_inv   = 1'b0;
        s_data  = 8'h00;
    endtask

    // s_inv is driven inverted on later beats: only beat 0 may matter
    task automatic frame(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input logic inv);
        beat(d0, 1'b0, inv);
        beat(d1, 1'b0, ~inv);
        beat(d2, 1'b0, ~inv);
        beat(d3, 1'b1, ~inv);
    endtask

    task automatic expect_par(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_m_valid"}, m_valid, 1);
            chk({tag, "_m_idx"},   m_idx, k);
            chk({tag, "_m_data"},  m_data, e[k]);
            chk({tag, "_m_last"},  m_last, (k == 3));
            chk({tag, "_s_ready"}, s_ready, 0);
            step();
        end
        chk({tag, "_done_s_ready"}, s_ready, 1);
        chk({tag, "_done_m_valid"}, m_valid, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_s_ready"},   s_ready, 1);
        chk({tag, "_m_valid"},   m_valid, 0);
        chk({tag, "_m_last"},    m_last, 0);
        chk({tag, "_cfg_err"},   cfg_err, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_m_data"},    m_data, 0);
        chk({tag, "_m_idx"},     m_idx, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_col = '0; cfg_shift = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_inv = 1'b0; m_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_reset_outs("reset");
        step();

        // Single-symbol frame, normal mode
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_par("single", 8'h02, 8'h04, 8'h08, 8'h10);

        // Same frame, inverse mode
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        expect_par("inverse", 8'h80, 8'h40, 8'h20, 8'h10);

        // Mixed frame: p1 = 04^10, p2 = 08^40
        frame(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        expect_par("mixed", 8'h06, 8'h14, 8'h48, 8'h11);

        // Accepted config write while idle: tbl[0][0] = 3
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_shift = 3'd3;
        step();
        cfg_we = 1'b0;
        chk("cfgok_err", cfg_err, 0);
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        // Rejected write during EMIT, m_ready held low meanwhile
        m_ready = 1'b0;
        cfg_we = 1'b1; cfg_shift = 3'd1;
        step();
        cfg_we = 1'b0;
        chk("cfgemit_err", cfg_err, 1);
        step();
        chk("cfgemit_err_drop", cfg_err, 0);
        m_ready = 1'b1;
        expect_par("cfgwr", 8'h08, 8'h04, 8'h08, 8'h10);
        // Rejected write colliding with a beat at col 0
        cfg_we = 1'b1; cfg_shift = 3'd1;
        beat(8'h01, 1'b0, 1'b0);
        cfg_we = 1'b0;
        chk("cfgbeat_err", cfg_err, 1);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b1, 1'b0);
        expect_par("cfgkept", 8'h08, 8'h04, 8'h08, 8'h10);

        // Backpressure on m_idx 1
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("bp_idx0", m_data, 8'h08);
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_idx",   m_idx, 1);
            chk("bp_hold_data",  m_data, 8'h04);
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_hold_ready", s_ready, 0);
            chk("bp_hold_last",  m_last, 0);
            step();
        end
        chk("bp_still_data", m_data, 8'h04);
        m_ready = 1'b1;
        step();
        chk("bp_idx2", m_data, 8'h08);
        chk("bp_idx2_ready", s_ready, 0);
        step();
        chk("bp_idx3", m_data, 8'h10);
        chk("bp_idx3_last", m_last, 1);
        chk("bp_idx3_ready", s_ready, 0);
        step();
        chk("bp_end_ready", s_ready, 1);

        // Early s_last on beat 2
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b1, 1'b0);
        chk("early_ferr", frame_err, 1);
        chk("early_mvalid", m_valid, 0);
        step();
        chk("early_ferr_drop", frame_err, 0);
        chk("early_mvalid2", m_valid, 0);
        chk("early_sready", s_ready, 1);
        // Missing s_last on beat 3
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_par("prelate", 8'h08, 8'h04, 8'h08, 8'h10);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        chk("late_ferr", frame_err, 1);
        chk("late_mvalid", m_valid, 0);
        // Next good frame: column 1 shifts 2,4,6,0
        frame(8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
        expect_par("afterr", 8'h04, 8'h10, 8'h40, 8'h01);

        // Reset during EMIT restores outputs and default table
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        m_ready = 1'b0;
        step();
        chk("prerst_valid", m_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        chk_reset_outs("rst_emit");
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_par("postrst", 8'h02, 8'h04, 8'h08, 8'h10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
